// File: rtl/noc_output_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// noc_arb_pkg
// Shared types and defaults for the mesh router output arbiter and the
// round-robin picker. The router imports the same defaults so the port count
// and flit width stay consistent across the slice.
//   arb_state_t : output arbiter FSM states (idle / packet locked)
//   port_idx_t  : index of one router port
//   rr_next     : wrap-around successor of a port index
// ---------------------------------------------------------------------------
package noc_arb_pkg;

    localparam int ARB_N      = 5;
    localparam int ARB_FLIT_W = 32;
    localparam int ARB_IDX_W  = $clog2(ARB_N);

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef logic [ARB_IDX_W-1:0] port_idx_t;

    // Successor of idx in a ring of n ports (n-1 wraps back to 0).
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/noc_output_arbiter_if.sv
// ---------------------------------------------------------------------------
// noc_output_arbiter_if
// Handshake bundle between N router inputs, the output arbiter and the
// downstream neighbour.
//   in_valid/in_data/in_last : flits offered by each input
//   in_ready                 : flit of input i accepted this cycle
//   out_valid/out_data/out_last : registered flit toward downstream
//   out_avail                : downstream can take a flit this cycle
// Modports:
//   master : the arbiter (owns in_ready and the out_* link)
//   slave  : the environment (inputs and downstream receiver)
// ---------------------------------------------------------------------------
interface noc_output_arbiter_if
    import noc_arb_pkg::*;
#(
    parameter int N      = ARB_N,
    parameter int FLIT_W = ARB_FLIT_W
);

    logic [N-1:0]             in_valid;
    logic [N-1:0][FLIT_W-1:0] in_data;
    logic [N-1:0]             in_last;
    logic [N-1:0]             in_ready;
    logic                     out_valid;
    logic [FLIT_W-1:0]        out_data;
    logic                     out_last;
    logic                     out_avail;

    modport master (
        input  in_valid, in_data, in_last, out_avail,
        output in_ready, out_valid, out_data, out_last
    );

    modport slave (
        output in_valid, in_data, in_last, out_avail,
        input  in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/noc_output_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// noc_rr_pick
// Combinational rotate-priority picker. Scans req starting at ptr, then
// ptr+1, ... wrapping modulo N, and reports the first asserted index.
// Shared with the router's input-VC arbitration.
//   req     : request vector, one bit per port
//   ptr     : highest-priority index this cycle (must be < N)
//   gnt_idx : first requesting index at or after ptr (0 when none)
//   any     : at least one request present
// ---------------------------------------------------------------------------
module noc_rr_pick #(
    parameter int N = 5
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IDX_W = $clog2(N);

    // Walk the ring from the farthest offset back to ptr so that the
    // closest requester to ptr is the last one written and therefore wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx[IDX_W-1:0]]) begin
                gnt_idx = idx[IDX_W-1:0];
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// ---------------------------------------------------------------------------
// noc_output_arbiter
// Wormhole output-port arbiter for one mesh router output. One packet at a
// time owns the link; owners are chosen round-robin and keep the grant until
// their tail flit is forwarded. The forwarded flit is registered and only
// advances when downstream signals availability.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : noc_output_arbiter_if.master (inputs, in_ready, out_* link)
//   owner     : index of the currently locked input (debug)
//   busy      : a packet holds the output
//   wdog_err  : one-cycle pulse when the stall watchdog releases a grant
// Configuration:
//   NOC_ARB_WATCHDOG_EN : when defined, an owner that makes no progress for
//                         WDOG_CYCLES locked cycles loses its grant. When
//                         undefined, the grant is held indefinitely and
//                         wdog_err is tied low.
// ---------------------------------------------------------------------------
module noc_output_arbiter
    import noc_arb_pkg::*;
#(
    parameter int N           = ARB_N,
    parameter int FLIT_W      = ARB_FLIT_W,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_output_arbiter_if.master bus,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 wdog_err
);

    localparam int IDX_W = $clog2(N);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ownerIdx_q, ownerIdx_d;
    logic [IDX_W-1:0]  rrPtr_q, rrPtr_d;
    logic [IDX_W-1:0]  ownerNext;
    logic [IDX_W-1:0]  pickIdx;
    logic              pickAny;
    logic              loadOk;
    logic              xfer;
    logic              wdogFire;

    logic              outValid_q;
    logic [FLIT_W-1:0] outData_q;
    logic              outLast_q;

    noc_rr_pick #(
        .N (N)
    ) u_pick (
        .req     (bus.in_valid),
        .ptr     (rrPtr_q),
        .gnt_idx (pickIdx),
        .any     (pickAny)
    );

    // The output register can accept a new flit when it is empty or its
    // current flit leaves this cycle.
    assign loadOk    = !outValid_q || bus.out_avail;
    assign xfer      = (state_q == ARB_LOCKED) && bus.in_valid[ownerIdx_q] && loadOk;
    assign ownerNext = IDX_W'(rr_next(int'(ownerIdx_q), N));

`ifdef NOC_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES) + 1;

    logic [CNT_W-1:0] wdogCnt_q, wdogCnt_d;
    logic             wdogErr_q;

    assign wdogFire = (state_q == ARB_LOCKED) && !xfer
                      && (wdogCnt_q == CNT_W'(WDOG_CYCLES - 1));

    // Count consecutive locked cycles without progress; any transfer, the
    // idle state or the release itself restarts the count.
    always_comb begin
        wdogCnt_d = wdogCnt_q + CNT_W'(1);
        if ((state_q != ARB_LOCKED) || xfer || wdogFire) begin
            wdogCnt_d = '0;
        end
    end

    // Counter and the registered release pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdogCnt_q <= '0;
            wdogErr_q <= 1'b0;
        end else begin
            wdogCnt_q <= wdogCnt_d;
            wdogErr_q <= wdogFire;
        end
    end

    assign wdog_err = wdogErr_q;
`else
    logic [31:0] unused_wdogCycles;

    assign unused_wdogCycles = WDOG_CYCLES;
    assign wdogFire          = 1'b0;
    assign wdog_err          = 1'b0;
`endif

    // State register: FSM state, locked owner and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            ownerIdx_q <= '0;
            rrPtr_q    <= '0;
        end else begin
            state_q    <= state_d;
            ownerIdx_q <= ownerIdx_d;
            rrPtr_q    <= rrPtr_d;
        end
    end

    // Next state: arbitrate in IDLE, release after the tail (or a watchdog
    // timeout) and move the pointer just past the releasing owner.
    always_comb begin
        state_d    = state_q;
        ownerIdx_d = ownerIdx_q;
        rrPtr_d    = rrPtr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pickAny) begin
                    state_d    = ARB_LOCKED;
                    ownerIdx_d = pickIdx;
                end
            end
            ARB_LOCKED: begin
                if ((xfer && bus.in_last[ownerIdx_q]) || wdogFire) begin
                    state_d = ARB_IDLE;
                    rrPtr_d = ownerNext;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // FSM outputs: only the locked owner sees ready, gated by output space.
    always_comb begin
        bus.in_ready = '0;
        busy         = 1'b0;
        if (state_q == ARB_LOCKED) begin
            bus.in_ready[ownerIdx_q] = loadOk;
            busy                     = 1'b1;
        end
    end

    // Output flit register: load on transfer, drop valid once downstream
    // has taken the flit and nothing replaces it, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outLast_q  <= 1'b0;
        end else if (xfer) begin
            outValid_q <= 1'b1;
            outData_q  <= bus.in_data[ownerIdx_q];
            outLast_q  <= bus.in_last[ownerIdx_q];
        end else if (bus.out_avail) begin
            outValid_q <= 1'b0;
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.out_data  = outData_q;
    assign bus.out_last  = outLast_q;
    assign owner         = ownerIdx_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_output_arbiter
// Self-checking bench for noc_output_arbiter. Directed steps cover single
// flit latency, contention order, pointer wrap, backpressure, async reset and
// the stall watchdog (NOC_ARB_WATCHDOG_EN selects the expected behaviour).
// Randomized packets are checked against a packet-level round-robin model.
// ---------------------------------------------------------------------------
module tb_noc_output_arbiter;
   import noc_arb_pkg::*;

   localparam int N    = 5;
   localparam int FW   = 32;
   localparam int WDOG = 8;
   localparam int MAXF = 64;

   typedef struct packed {
      logic [FW-1:0] data;
      logic          last;
   } flit_t;

   logic      clk;
   logic      rst;
   port_idx_t owner;
   logic      busy;
   logic      wdog_err;

   noc_output_arbiter_if #(.N(N), .FLIT_W(FW)) bus ();

   noc_output_arbiter #(
      .N           (N),
      .FLIT_W      (FW),
      .WDOG_CYCLES (WDOG)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .owner    (owner),
      .busy     (busy),
      .wdog_err (wdog_err)
   );

   int          nChecks = 0;
   int          nFails  = 0;
   flit_t       mem [N][MAXF];
   int          wrPtr [N];
   int          rdPtr [N];
   logic [N-1:0] accept;
   flit_t       expQ [$];
   int          expIdx;
   int          fireCyc [$];
   int          cyc;
   int          mPtr;
   bit          gapsOn;
   bit          randAvail;
   int          stallStart;
   int          stallLen;
   logic        prevStall;
   logic [FW:0] prevFlit;

   // Free-running clock, posedges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the bench always ends.
   initial begin
      #500000;
      $display("[TB] FAIL globalTimeout: simulation did not finish, observed time %0t", $time);
      $fatal(1, "[TB] time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic doReset();
      rst           = 1'b1;
      bus.in_valid  = '0;
      bus.in_last   = '0;
      bus.in_data   = '0;
      bus.out_avail = 1'b1;
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      mPtr = 0;
      #1;
   endtask

   task automatic clearQueues();
      for (int i = 0; i < N; i++) begin
         wrPtr[i] = 0;
         rdPtr[i] = 0;
      end
      expQ.delete();
      fireCyc.delete();
   endtask

   task automatic addPacket(input int src, input int len);
      for (int k = 0; k < len; k++) begin
         mem[src][wrPtr[src]].data = $urandom;
         mem[src][wrPtr[src]].last = (k == len - 1);
         wrPtr[src]++;
      end
   endtask

   // Reference model: whole packets leave in round-robin order over the
   // inputs that still hold packets, starting at mPtr.
   task automatic buildExpected();
      int    rp [N];
      int    pick;
      flit_t f;
      for (int i = 0; i < N; i++) rp[i] = rdPtr[i];
      forever begin
         pick = -1;
         for (int off = N - 1; off >= 0; off--) begin
            if (rp[(mPtr + off) % N] < wrPtr[(mPtr + off) % N]) pick = (mPtr + off) % N;
         end
         if (pick < 0) break;
         do begin
            f = mem[pick][rp[pick]];
            rp[pick]++;
            expQ.push_back(f);
         end while (!f.last);
         mPtr = (pick + 1) % N;
      end
   endtask

   // Drive one cycle of inputs: heads are always offered, body flits may
   // be withheld when gaps are enabled.
   task automatic applyStimulus();
      bit head;
      for (int i = 0; i < N; i++) begin
         if (rdPtr[i] < wrPtr[i]) begin
            if (rdPtr[i] == 0) head = 1'b1;
            else               head = mem[i][rdPtr[i] - 1].last;
            bus.in_valid[i] = head || !gapsOn || ($urandom_range(0, 3) != 0);
            bus.in_data[i]  = mem[i][rdPtr[i]].data;
            bus.in_last[i]  = mem[i][rdPtr[i]].last;
         end else begin
            bus.in_valid[i] = 1'b0;
            bus.in_data[i]  = $urandom;
            bus.in_last[i]  = 1'($urandom_range(0, 1));
         end
      end
      if (cyc >= stallStart && cyc < stallStart + stallLen) bus.out_avail = 1'b0;
      else if (randAvail)                                bus.out_avail = ($urandom_range(0, 2) != 0);
      else                                               bus.out_avail = 1'b1;
   endtask

   task automatic monitorCycle();
      checkOutput("readyOneHot", 64'($onehot0(bus.in_ready)), 1);
      if (bus.out_valid && !bus.out_avail) checkOutput("readyLowOnStall", bus.in_ready, 0);
      if (prevStall) begin
         checkOutput("stallValid", bus.out_valid, 1);
         checkOutput("stallData", {bus.out_data, bus.out_last}, prevFlit);
      end
      if (bus.out_valid && bus.out_avail) begin
         if (expIdx < expQ.size()) begin
            checkOutput("flitData", bus.out_data, expQ[expIdx].data);
            checkOutput("flitLast", bus.out_last, expQ[expIdx].last);
            fireCyc.push_back(cyc);
            expIdx++;
         end else begin
            checkOutput("extraFlit", bus.out_valid, 0);
         end
      end
      prevStall = bus.out_valid && !bus.out_avail;
      prevFlit  = {bus.out_data, bus.out_last};
      accept    = bus.in_valid & bus.in_ready;
   endtask

   task automatic runStream(input int budget);
      bit done;
      expIdx    = 0;
      prevStall = 1'b0;
      buildExpected();
      for (cyc = 0; cyc < budget; cyc++) begin
         done = (expIdx == expQ.size());
         for (int i = 0; i < N; i++) if (rdPtr[i] < wrPtr[i]) done = 1'b0;
         if (done) break;
         @(negedge clk);
         applyStimulus();
         #1;
         monitorCycle();
         @(posedge clk);
         for (int i = 0; i < N; i++) if (accept[i]) rdPtr[i]++;
      end
      checkOutput("streamComplete", expIdx, expQ.size());
      @(negedge clk);
      bus.in_valid  = '0;
      bus.out_avail = 1'b1;
      stallStart    = -100;
      stallLen      = 0;
   endtask

   initial begin
      bit sawErr;
      int n;
      gapsOn     = 1'b0;
      randAvail  = 1'b0;
      stallStart = -100;
      stallLen   = 0;
      doReset();

      $display("[TB] reset state");
      checkOutput("rstOutValid", bus.out_valid, 0);
      checkOutput("rstOutData", bus.out_data, 0);
      checkOutput("rstOutLast", bus.out_last, 0);
      checkOutput("rstInReady", bus.in_ready, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstOwner", owner, 0);
      checkOutput("rstWdogErr", wdog_err, 0);

      $display("[TB] single-flit packet");
      @(negedge clk);
      bus.in_valid   = 5'b00100;
      bus.in_last    = 5'b00100;
      bus.in_data[2] = 32'hA5A5_0001;
      #1;
      checkOutput("t1IdleReady", bus.in_ready, 0);
      checkOutput("t1IdleBusy", busy, 0);
      @(negedge clk); #1;
      checkOutput("t1Ready", bus.in_ready, 5'b00100);
      checkOutput("t1Owner", owner, 2);
      checkOutput("t1Busy", busy, 1);
      checkOutput("t1NoOutYet", bus.out_valid, 0);
      @(negedge clk);
      bus.in_valid   = 5'b01001;
      bus.in_last    = 5'b01001;
      #1;
      checkOutput("t1OutValid", bus.out_valid, 1);
      checkOutput("t1OutData", bus.out_data, 32'hA5A5_0001);
      checkOutput("t1OutLast", bus.out_last, 1);
      checkOutput("t1BusyDone", busy, 0);
      @(negedge clk); #1;
      checkOutput("t1PtrIs3", owner, 3);
      bus.in_valid = '0;

      $display("[TB] contention 0/1/4");
      doReset();
      clearQueues();
      addPacket(0, 3);
      addPacket(1, 3);
      addPacket(4, 3);
      runStream(200);
      checkOutput("t2FirstLatency", fireCyc.size() > 0 ? fireCyc[0] : -1, 2);
      for (int k = 1; k < fireCyc.size(); k++) begin
         checkOutput($sformatf("t2Gap%0d", k), fireCyc[k] - fireCyc[k-1], (k % 3 == 0) ? 2 : 1);
      end

      $display("[TB] pointer wrap-around");
      doReset();
      clearQueues();
      addPacket(3, 1);
      runStream(100);
      clearQueues();
      addPacket(0, 2);
      addPacket(4, 2);
      runStream(100);
      checkOutput("t3WrapOwner", owner, 0);

      $display("[TB] backpressure");
      doReset();
      clearQueues();
      addPacket(1, 6);
      stallStart = 4;
      stallLen   = 5;
      runStream(200);

      $display("[TB] randomized traffic");
      doReset();
      gapsOn    = 1'b1;
      randAvail = 1'b1;
      for (int r = 0; r < 4; r++) begin
         clearQueues();
         for (int i = 0; i < N; i++) begin
            for (int p = $urandom_range(0, 4); p > 0; p--) addPacket(i, $urandom_range(1, 4));
         end
         runStream(3000);
      end
      gapsOn    = 1'b0;
      randAvail = 1'b0;

      $display("[TB] async reset mid-packet");
      doReset();
      @(negedge clk);
      bus.in_valid   = 5'b00010;
      bus.in_last    = 5'b00000;
      bus.in_data[1] = 32'h1234_5678;
      @(negedge clk);
      @(negedge clk); #1;
      checkOutput("t5PreOwner", owner, 1);
      checkOutput("t5PreValid", bus.out_valid, 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("t5OutValid", bus.out_valid, 0);
      checkOutput("t5Busy", busy, 0);
      checkOutput("t5Owner", owner, 0);
      checkOutput("t5InReady", bus.in_ready, 0);
      @(negedge clk);
      bus.in_valid = '0;
      rst          = 1'b0;
      @(negedge clk); #1;
      checkOutput("t5NoTail", bus.out_valid, 0);
      checkOutput("t5StillIdle", busy, 0);

      $display("[TB] stall watchdog");
      doReset();
      @(negedge clk);
      bus.in_valid   = 5'b01100;
      bus.in_last    = 5'b01000;
      bus.in_data[2] = 32'hDEAD_0002;
      bus.in_data[3] = 32'hBEEF_0003;
      @(negedge clk); #1;
      checkOutput("t6Owner", owner, 2);
      @(negedge clk);
      bus.in_valid[2] = 1'b0;
      #1;
      checkOutput("t6HeadOut", bus.out_data, 32'hDEAD_0002);
`ifdef NOC_ARB_WATCHDOG_EN
      n = 0;
      while (n < 20) begin
         @(negedge clk); #1;
         n++;
         if (wdog_err) break;
      end
      checkOutput("t6WdogLatency", n, WDOG);
      checkOutput("t6ReleasedBusy", busy, 0);
      @(negedge clk); #1;
      checkOutput("t6PulseWidth", wdog_err, 0);
      checkOutput("t6NextBusy", busy, 1);
      checkOutput("t6NextOwner", owner, 3);
`else
      sawErr = 1'b0;
      repeat (20) begin
         @(negedge clk); #1;
         sawErr = sawErr | wdog_err;
      end
      checkOutput("t6NoWdogErr", sawErr, 0);
      checkOutput("t6HeldBusy", busy, 1);
      checkOutput("t6HeldOwner", owner, 2);
      checkOutput("t6OtherBlocked", bus.in_ready[3], 0);
`endif
      bus.in_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
